// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request bundle used by the register-file
// writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 16;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// load issues and cleared when the register file commits the write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Clear is applied before set so a newer load to the same register wins.
  always_comb begin
    pending_next = pending;
    if (clr_en) pending_next[clr_rd] = 1'b0;
    if (set_en && (set_rd != '0)) pending_next[set_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

  assign rs1_busy = (rs1 != '0) && pending[rs1];
  assign rs2_busy = (rs2 != '0) && pending[rs2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (port 0) and the load unit (port 1), with a registered write stage.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int CNT_W    = regfile_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [XLEN-1:0]   wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [XLEN-1:0]   wb1_data,
  output logic              wb1_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_rd_din,
  output logic [CNT_W-1:0]  conflict_cnt
);

  wb_req req0;
  wb_req req1;
  wb_req winner;
  logic  last_grant;
  logic  transfer;

  assign req0 = '{valid: wb0_valid, rd: wb0_rd, data: wb0_data};
  assign req1 = '{valid: wb1_valid, rd: wb1_rd, data: wb1_data};

  // On a tie the port that did not win last time gets the grant.
  assign wb0_ready = reset && req0.valid && (!req1.valid || last_grant);
  assign wb1_ready = reset && req1.valid && (!req0.valid || !last_grant);
  assign transfer  = wb0_ready || wb1_ready;
  assign winner    = wb1_ready ? req1 : req0;

  // Writes to x0 are accepted and consumed but never strobe the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_write_enable <= 1'b0;
      rf_rd           <= '0;
      rf_rd_din       <= '0;
      last_grant      <= 1'b1;
    end else if (transfer) begin
      rf_write_enable <= (winner.rd != '0);
      rf_rd           <= winner.rd;
      rf_rd_din       <= winner.data;
      last_grant      <= wb1_ready;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (wb0_valid && wb1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (issue_valid),
    .set_rd  (issue_rd),
    .clr_en  (rf_write_enable),
    .clr_rd  (rf_rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb0_valid;
  logic [ADDR_W-1:0] wb0_rd;
  logic [XLEN-1:0]   wb0_data;
  logic              wb0_ready;
  logic              wb1_valid;
  logic [ADDR_W-1:0] wb1_rd;
  logic [XLEN-1:0]   wb1_data;
  logic              wb1_ready;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]   rf_rd_din;
  logic [CNT_W-1:0]  conflict_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(
    .XLEN    (XLEN),
    .NUM_REGS(32),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wb0_valid      (wb0_valid),
    .wb0_rd         (wb0_rd),
    .wb0_data       (wb0_data),
    .wb0_ready      (wb0_ready),
    .wb1_valid      (wb1_valid),
    .wb1_rd         (wb1_rd),
    .wb1_data       (wb1_data),
    .wb1_ready      (wb1_ready),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rf_write_enable(rf_write_enable),
    .rf_rd          (rf_rd),
    .rf_rd_din      (rf_rd_din),
    .conflict_cnt   (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, then settles before checks.
  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] r0,
                               input logic [XLEN-1:0] d0, input logic v1,
                               input logic [ADDR_W-1:0] r1, input logic [XLEN-1:0] d1,
                               input logic iv, input logic [ADDR_W-1:0] ird);
    @(negedge clk);
    wb0_valid   = v0;
    wb0_rd      = r0;
    wb0_data    = d0;
    wb1_valid   = v1;
    wb1_rd      = r1;
    wb1_data    = d1;
    issue_valid = iv;
    issue_rd    = ird;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset       = 1'b0;
    wb0_valid   = 1'b0;
    wb1_valid   = 1'b0;
    issue_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [ADDR_W-1:0] r0;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] prev_rd;
    logic [XLEN-1:0]   prev_din;
    logic              exp0;

    reset       = 1'b0;
    wb0_valid   = 1'b1;
    wb0_rd      = 5'd3;
    wb0_data    = 32'd33;
    wb1_valid   = 1'b1;
    wb1_rd      = 5'd4;
    wb1_data    = 32'd44;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs1         = '0;
    rs2         = '0;

    // Reset held with both requesters valid
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_ready0", wb0_ready, 0);
    checkOutput("rst_ready1", wb1_ready, 0);
    checkOutput("rst_we", rf_write_enable, 0);
    checkOutput("rst_rd", rf_rd, 0);
    checkOutput("rst_din", rf_rd_din, 0);
    checkOutput("rst_cnt", conflict_cnt, 0);
    reset = 1'b1;
    #1;
    checkOutput("rel_ready0", wb0_ready, 1);
    checkOutput("rel_ready1", wb1_ready, 0);

    // Reset reasserted right after a transfer drops the registered write
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_we", rf_write_enable, 1);
    checkOutput("mid_rd", rf_rd, 3);
    checkOutput("mid_din", rf_rd_din, 33);
    checkOutput("mid_ready1", wb1_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("mid_we_after", rf_write_enable, 0);
    checkOutput("mid_rd_after", rf_rd, 0);
    checkOutput("mid_cnt_after", conflict_cnt, 0);

    // Single-port write on port 1
    doReset();
    applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
    checkOutput("single_ready1", wb1_ready, 1);
    checkOutput("single_ready0", wb0_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_we", rf_write_enable, 1);
    checkOutput("single_rd", rf_rd, 5);
    checkOutput("single_din", rf_rd_din, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("single_we_off", rf_write_enable, 0);
    checkOutput("single_rd_hold", rf_rd, 5);

    // Round-robin under continuous contention
    doReset();
    r0       = 5'd1;
    r1       = 5'd11;
    prev_rd  = '0;
    prev_din = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, r0, 32'd100 + 32'(r0), 1, r1, 32'd200 + 32'(r1), 0, 0);
      exp0 = (k % 2 == 0);
      checkOutput($sformatf("rr_ready0_%0d", k), wb0_ready, exp0);
      checkOutput($sformatf("rr_ready1_%0d", k), wb1_ready, !exp0);
      if (k > 0) checkOutput($sformatf("rr_rd_%0d", k), rf_rd, prev_rd);
      if (exp0) begin
        prev_rd  = r0;
        prev_din = 32'd100 + 32'(r0);
        r0       = r0 + 1'b1;
      end else begin
        prev_rd  = r1;
        prev_din = 32'd200 + 32'(r1);
        r1       = r1 + 1'b1;
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rr_rd_last", rf_rd, 12);
    checkOutput("rr_din_last", rf_rd_din, 212);
    checkOutput("rr_cnt", conflict_cnt, 4);

    // Write to x0 is accepted but never strobed; issue to x0 never pends
    doReset();
    applyStimulus(1, 0, 7, 0, 0, 0, 1, 0);
    checkOutput("x0_ready0", wb0_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_we", rf_write_enable, 0);
    rs1 = 5'd0;
    #1;
    checkOutput("x0_busy", rs1_busy, 0);

    // Scoreboard set, clear on commit, and set-wins on the same edge
    doReset();
    rs1 = 5'd8;
    rs2 = 5'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8);
    checkOutput("sb_busy_pre", rs1_busy, 0);
    applyStimulus(0, 0, 0, 1, 8, 32'd55, 0, 0);
    checkOutput("sb_busy_set", rs1_busy, 1);
    checkOutput("sb_ready1", wb1_ready, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_we", rf_write_enable, 1);
    checkOutput("sb_busy_commit", rs1_busy, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sb_busy_clear", rs1_busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8);
    applyStimulus(0, 0, 0, 1, 8, 32'd66, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 8);
    checkOutput("sb_busy_both", rs1_busy, 1);
    checkOutput("sb_we2", rf_write_enable, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rs2 = 5'd8;
    #1;
    checkOutput("sb_set_wins1", rs1_busy, 1);
    checkOutput("sb_set_wins2", rs2_busy, 1);
    checkOutput("sb_we_off", rf_write_enable, 0);

    // Saturating contention counter
    doReset();
    for (int k = 0; k < 20; k++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_cnt", conflict_cnt, 15);
    applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_hold", conflict_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
